// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and helpers for the chunked magnitude comparator.
// State encoding, result codes and sizing functions.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  function automatic int nchunk(input int w, input int c);
    return w / c;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle for seq_magnitude_comparator.
// master drives operands and takes results; slave is the comparator.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             greater;
  logic             lesser;
  logic             equal;
  logic             busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, greater, lesser, equal, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, greater, lesser, equal, busy
  );
endinterface

// File: rtl/seq_magnitude_comparator_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
// eq is implied by neither gt nor lt.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt
);
  assign gt = (x > y);
  assign lt = (x < y);
endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator, CHUNK bits per cycle, MSB first.
// Signed mode biases the sign bit so the scan is always unsigned.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input logic clk,
  input logic rst,
  seq_magnitude_comparator_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
  end
  if ($bits(bus.a) != WIDTH) begin : g_bad_bus
    $error("interface WIDTH does not match comparator WIDTH");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] ra, rb;
  logic [IW-1:0]    idx;
  logic [1:0]       res, res_n, cur;
  logic             gt_q, lt_q, eq_q;
  logic             gt_n, lt_n, eq_n;
  logic [CHUNK-1:0] cx, cy;
  logic             cgt, clt;
  logic             accept, last;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (idx == IW'(NCHUNK - 1));

  always_comb begin
    cx = '0;
    cy = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        cx = ra[WIDTH-1-i*CHUNK -: CHUNK];
        cy = rb[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk (
    .x  (cx),
    .y  (cy),
    .gt (cgt),
    .lt (clt)
  );

  // The first unequal chunk decides; later chunks never override it.
  assign cur = (res != RES_EQ) ? res :
               cgt ? RES_GT :
               clt ? RES_LT : RES_EQ;

  always_comb begin
    state_n = state;
    res_n   = res;
    gt_n    = gt_q;
    lt_n    = lt_q;
    eq_n    = eq_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = RUN;
          res_n   = RES_EQ;
        end
      end
      RUN: begin
        res_n = cur;
        if (last || (EARLY_EXIT != 0 && (cgt || clt))) begin
          state_n = HOLD;
          gt_n    = (cur == RES_GT);
          lt_n    = (cur == RES_LT);
          eq_n    = (cur == RES_EQ);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_n = IDLE;
          gt_n    = 1'b0;
          lt_n    = 1'b0;
          eq_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res   <= RES_EQ;
      idx   <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else begin
      state <= state_n;
      res   <= res_n;
      gt_q  <= gt_n;
      lt_q  <= lt_n;
      eq_q  <= eq_n;
      if (accept)
        idx <= '0;
      else if (state == RUN && !last)
        idx <= idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
    end else if (accept) begin
      ra <= bus.a ^ (bus.signed_mode ? MSB : '0);
      rb <= bus.b ^ (bus.signed_mode ? MSB : '0);
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);
  assign bus.greater   = gt_q;
  assign bus.lesser    = lt_q;
  assign bus.equal     = eq_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: three configurations,
// directed cases plus random operands against an arithmetic model.
module tb_seq_magnitude_comparator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(16)) if0 ();
  seq_magnitude_comparator_if #(.WIDTH(16)) if1 ();
  seq_magnitude_comparator_if #(.WIDTH(1))  if2 ();

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  seq_magnitude_comparator #(.WIDTH(1), .CHUNK(1), .EARLY_EXIT(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic drive_in(int d, bit v, logic [15:0] a, logic [15:0] b, bit sm);
    case (d)
      0: begin if0.in_valid = v; if0.a = a; if0.b = b; if0.signed_mode = sm; end
      1: begin if1.in_valid = v; if1.a = a; if1.b = b; if1.signed_mode = sm; end
      default: begin if2.in_valid = v; if2.a = a[0]; if2.b = b[0]; if2.signed_mode = sm; end
    endcase
  endtask

  // {in_ready, out_valid, greater, lesser, equal, busy}
  function automatic logic [5:0] obs(int d);
    case (d)
      0: return {if0.in_ready, if0.out_valid, if0.greater, if0.lesser, if0.equal, if0.busy};
      1: return {if1.in_ready, if1.out_valid, if1.greater, if1.lesser, if1.equal, if1.busy};
      default: return {if2.in_ready, if2.out_valid, if2.greater, if2.lesser, if2.equal, if2.busy};
    endcase
  endfunction

  // Full transaction with out_ready high; lat = -1 if no result in time.
  task automatic txn(int d, logic [15:0] a, logic [15:0] b, bit sm,
                     output int lat, output logic [2:0] gle);
    logic [5:0] o;
    drive_in(d, 1'b1, a, b, sm);
    @(posedge clk); #1;
    drive_in(d, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    lat = -1;
    o = obs(d);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      o = obs(d);
      if (o[4]) begin
        lat = i;
        break;
      end
    end
    gle = o[3:1];
    if (lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic void model(int w, int c, bit ee, logic [15:0] a, logic [15:0] b,
                                bit sm, output logic [2:0] gle, output int lat);
    longint va = longint'(a);
    longint vb = longint'(b);
    longint msk = (longint'(1) << c) - 1;
    int n = w / c;
    if (sm && a[w-1]) va = va - (longint'(1) << w);
    if (sm && b[w-1]) vb = vb - (longint'(1) << w);
    gle = {va > vb, va < vb, va == vb};
    lat = n;
    if (ee) begin
      for (int i = 0; i < n; i++) begin
        if (((longint'(a) >> (w - (i + 1) * c)) & msk) !=
            ((longint'(b) >> (w - (i + 1) * c)) & msk)) begin
          lat = i + 1;
          break;
        end
      end
    end
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (obs(d) !== 6'b100000) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %b want 100000", d, obs(d));
      end
    end
  endtask

  task automatic test_equal();
    int lat;
    logic [2:0] g;
    txn(0, 16'h1234, 16'h1234, 1'b0, lat, g);
    n_chk++;
    if (g !== 3'b001 || lat != 4) begin
      n_fail++;
      $display("FAIL equal: gle=%b lat=%0d want 001 lat=4", g, lat);
    end
  endtask

  task automatic test_msb();
    int lat;
    logic [2:0] g;
    txn(0, 16'h8000, 16'h7FFF, 1'b0, lat, g);
    n_chk++;
    if (g !== 3'b100 || lat != 1) begin
      n_fail++;
      $display("FAIL msb_unsigned: gle=%b lat=%0d want 100 lat=1", g, lat);
    end
    txn(0, 16'h8000, 16'h7FFF, 1'b1, lat, g);
    n_chk++;
    if (g !== 3'b010 || lat != 1) begin
      n_fail++;
      $display("FAIL msb_signed: gle=%b lat=%0d want 010 lat=1", g, lat);
    end
  endtask

  task automatic test_late();
    int lat;
    logic [2:0] g;
    txn(0, 16'h1235, 16'h1234, 1'b0, lat, g);
    n_chk++;
    if (g !== 3'b100 || lat != 4) begin
      n_fail++;
      $display("FAIL late_lsb: gle=%b lat=%0d want 100 lat=4", g, lat);
    end
    txn(1, 16'h2000, 16'h1FFF, 1'b0, lat, g);
    n_chk++;
    if (g !== 3'b100 || lat != 4) begin
      n_fail++;
      $display("FAIL no_early_exit: gle=%b lat=%0d want 100 lat=4", g, lat);
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [2:0] g, eg;
    logic [15:0] a, b;
    bit sm;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 30; k++) begin
        a  = 16'($urandom);
        sm = 1'($urandom);
        case ($urandom_range(0, 3))
          0: b = 16'($urandom);
          1: b = a;
          2: b = a ^ (16'(1) << $urandom_range(0, 15));
          default: b = a ^ 16'h8000;
        endcase
        model(16, 4, (d == 0), a, b, sm, eg, elat);
        txn(d, a, b, sm, lat, g);
        n_chk++;
        if (g !== eg || lat != elat) begin
          n_fail++;
          $display("FAIL random dut%0d a=%h b=%h s=%0d: gle=%b lat=%0d want %b lat=%0d",
                   d, a, b, sm, g, lat, eg, elat);
        end
      end
    end
  endtask

  task automatic test_hold();
    int lat = -1;
    bit seen = 0;
    if0.out_ready = 1'b0;
    drive_in(0, 1'b1, 16'h0005, 16'h0003, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (obs(0)[4]) begin
        lat = i;
        break;
      end
    end
    n_chk++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL hold_latency: got %0d want 4", lat);
    end
    for (int i = 0; i < 6; i++) begin
      drive_in(0, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
      @(posedge clk); #1;
      n_chk++;
      if (obs(0) !== 6'b011001) begin
        n_fail++;
        $display("FAIL hold_stable cyc%0d: got %b want 011001", i, obs(0));
      end
    end
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (obs(0) !== 6'b100000) begin
      n_fail++;
      $display("FAIL hold_release: got %b want 100000", obs(0));
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (obs(0)[4] || obs(0)[0]) seen = 1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL hold_ignored_input: got activity want idle");
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    drive_in(0, 1'b1, 16'h1234, 16'h1234, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if (obs(0) !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_mid: got %b want 100000", obs(0));
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (obs(0)[4]) seen = 1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_discard: out_valid seen want none");
    end
  endtask

  task automatic test_one_bit();
    logic [2:0] want [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int lat;
    logic [2:0] g;
    logic [15:0] a, b;
    for (int k = 0; k < 4; k++) begin
      a = 16'(k >> 1);
      b = 16'(k & 1);
      txn(2, a, b, 1'b0, lat, g);
      n_chk++;
      if (g !== want[k] || lat != 1) begin
        n_fail++;
        $display("FAIL one_bit a=%0d b=%0d: gle=%b lat=%0d want %b lat=1",
                 a[0], b[0], g, lat, want[k]);
      end
    end
  endtask

  initial begin
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive_in(1, 1'b0, 16'h0, 16'h0, 1'b0);
    drive_in(2, 1'b0, 16'h0, 16'h0, 1'b0);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    if2.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_equal();
    test_msb();
    test_late();
    test_random();
    test_hold();
    test_reset_mid();
    test_one_bit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
